// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the controller stage, the ALU and the next stage.
// master drives the op/operands and out_ready; slave returns the result fields.
interface alu_exec_unit_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         controller;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               carry_in;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   remainder;
  logic               carry_out;
  logic               div_by_zero;
  logic               illegal_op;

  modport master (
    output in_valid, controller, a, b, carry_in, out_ready,
    input  in_ready, out_valid, result, remainder,
    input  carry_out, div_by_zero, illegal_op
  );

  modport slave (
    input  in_valid, controller, a, b, carry_in, out_ready,
    output in_ready, out_valid, result, remainder,
    output carry_out, div_by_zero, illegal_op
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute stage: 1-cycle logic/ADD/SUB, WIDTH-step shift-add MUL and
// restoring DIV. Ports: clock, reset (async, low), bus (slave handshake).
module alu_exec_unit #(
  parameter int WIDTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_NAND = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_ADD  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e             state_q, state_d;
  logic               mul_q, mul_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               co_q, co_d;
  logic               dbz_q, dbz_d;
  logic               ill_q, ill_d;

  logic [WIDTH-1:0]   lres;
  logic [WIDTH:0]     add_s, sub_s;
  logic [WIDTH:0]     mul_s, div_sh, div_t;
  logic               accept;

  assign accept = bus.in_valid && (state_q == IDLE);

  assign add_s = {1'b0, bus.a} + {1'b0, bus.b}
               + (WIDTH+1)'(bus.carry_in);
  // Bit WIDTH of the difference is the borrow (a < b + carry_in).
  assign sub_s = {1'b0, bus.a} - {1'b0, bus.b}
               - (WIDTH+1)'(bus.carry_in);

  // MUL: acc = {partial high, remaining multiplier}; add then shift right.
  assign mul_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, m_q} : '0);
  // DIV: acc = {partial remainder, dividend/quotient}; shift left, trial.
  assign div_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_t  = div_sh - {1'b0, m_q};

  always_comb begin
    state_d = state_q;
    mul_d   = mul_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rem_d   = rem_q;
    co_d    = co_q;
    dbz_d   = dbz_q;
    ill_d   = ill_q;
    lres    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DONE;
          cnt_d   = '0;
          rem_d   = '0;
          co_d    = 1'b0;
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
          unique case (bus.controller)
            OP_AND:  lres = bus.a & bus.b;
            OP_NAND: lres = ~(bus.a & bus.b);
            OP_OR:   lres = bus.a | bus.b;
            OP_NOR:  lres = ~(bus.a | bus.b);
            OP_XOR:  lres = bus.a ^ bus.b;
            OP_XNOR: lres = ~(bus.a ^ bus.b);
            OP_NOT:  lres = ~bus.a;
            OP_ADD: begin
              lres = add_s[WIDTH-1:0];
              co_d = add_s[WIDTH];
            end
            OP_SUB: begin
              lres = sub_s[WIDTH-1:0];
              co_d = sub_s[WIDTH];
            end
            OP_MUL: begin
              state_d = ITER;
              mul_d   = 1'b1;
              m_d     = bus.a;
              acc_d   = {{WIDTH{1'b0}}, bus.b};
            end
            OP_DIV: begin
              if (bus.b == '0) begin
                lres  = '1;
                rem_d = bus.a;
                dbz_d = 1'b1;
              end else begin
                state_d = ITER;
                mul_d   = 1'b0;
                m_d     = bus.b;
                acc_d   = {{WIDTH{1'b0}}, bus.a};
              end
            end
            default: ill_d = 1'b1;
          endcase
          res_d = {{WIDTH{1'b0}}, lres};
        end
      end
      ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (mul_q) begin
          acc_d = {mul_s, acc_q[WIDTH-1:1]};
        end else if (!div_t[WIDTH]) begin
          acc_d = {div_t[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == LAST) begin
          state_d = DONE;
          if (mul_q) begin
            res_d = acc_d;
          end else begin
            res_d = {{WIDTH{1'b0}}, acc_d[WIDTH-1:0]};
            rem_d = acc_d[2*WIDTH-1:WIDTH];
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mul_q   <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      co_q    <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mul_q   <= mul_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      co_q    <= co_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.result      = res_q;
  assign bus.remainder   = rem_q;
  assign bus.carry_out   = co_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal_op  = ill_q;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Sequential ALU execution stage that sits directly downstream of control_circuit. It consumes the 4-bit controller code plus operands a, b and carry_in. Logic, add and subtract complete in one cycle; multiply (shift-add) and divide (restoring) are iterative over WIDTH cycles. Results are handed to the next stage through a valid/ready handshake.

Parameters:
WIDTH, 4, operand width; result is 2*WIDTH; MUL and DIV take WIDTH iteration cycles.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
in_valid  input  1  upstream presents controller/a/b/carry_in.
in_ready  output  1  block can accept; equals (state==IDLE).
controller  input  4  op code: 0000 AND, 0001 NAND, 0010 OR, 0011 NOR, 0100 XOR, 0101 XNOR, 0110 NOT(a), 0111 ADD, 1000 SUB, 1001 MUL, 1010 DIV, 1011-1111 illegal.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
carry_in  input  1  carry for ADD, borrow for SUB; ignored otherwise.
out_valid  output  1  result fields valid.
out_ready  input  1  downstream accepts result.
result  output  2*WIDTH  product for MUL; quotient for DIV; otherwise zero-extended WIDTH-bit result.
remainder  output  WIDTH  DIV remainder; 0 for all other ops.
carry_out  output  1  ADD carry / SUB borrow; 0 for all other ops.
div_by_zero  output  1  DIV with b==0.
illegal_op  output  1  controller in 1011-1111.

Behaviour:
- Reset (reset==0, async): state=IDLE. out_valid, result, remainder, carry_out, div_by_zero, illegal_op and all iteration registers are cleared to 0. Inputs are ignored while reset is low. Assertion mid-operation aborts the operation with no output.
- FSM states: IDLE, ITER, DONE.
- IDLE: capture the op, a, b and carry_in on in_valid && in_ready.
  - Single-cycle ops (logic, ADD, SUB, illegal, DIV with b==0) go to DONE.
  - MUL, and DIV with b!=0, go to ITER with count=0.
- ITER: one step per clock. count increments; after step WIDTH-1 the next state is DONE.
- DONE: out_valid=1 and all output fields held stable. On out_valid && out_ready, go to IDLE; in_ready rises the following cycle. No bypass: minimum issue interval is 2 cycles for single-cycle ops and WIDTH+2 cycles for MUL/DIV.
- Latency, with the accept edge as cycle 0:
  - single-cycle ops: out_valid at cycle 1.
  - MUL and DIV: out_valid at cycle WIDTH+1.
- Logic ops are bitwise on WIDTH bits; NOT uses a only.
- ADD: {carry_out, sum} = a + b + carry_in; result = {0, sum}.
- SUB: diff = a - b - carry_in, modulo 2^WIDTH; carry_out = 1 if a < b + carry_in; result = {0, diff}.
- MUL: unsigned shift-add, LSB of b first; 2*WIDTH product, no overflow possible.
- DIV: unsigned restoring division, MSB first. result = {0, quotient}; remainder = final partial remainder.
- DIV with b==0: result = {0, all-ones}, remainder = a, div_by_zero=1, single-cycle latency.
- Illegal op: result=0, remainder=0, carry_out=0, illegal_op=1, single-cycle latency.
- Flags are cleared on each new accept and are valid only with out_valid.
- While busy (ITER/DONE): in_ready=0; in_valid is ignored and the upstream must hold its inputs.
- Backpressure: DONE holds indefinitely while out_ready=0.
- Simultaneous events: an in_valid arriving on the same edge that the result is taken is not accepted (in_ready is still 0 at that edge).

Test Plan:
- Logic sweep, a=1010, b=0101, controller 0000..0110 -> results 0000, 1111, 1111, 0000, 1111, 0000, 0101; out_valid exactly 1 cycle after accept; carry_out=0.
- ADD 0011+0001 ci=0 -> result 0x04, carry_out=0. ADD 1111+0001 ci=1 -> 0x01, carry_out=1. SUB 0100-0010 -> 0x02, carry_out=0. SUB 0010-0100 -> 0x0E, carry_out=1.
- MUL 0011*0010 -> 0x06; MUL 1111*1111 -> 0xE1. out_valid exactly 5 cycles after accept; in_ready=0 throughout.
- DIV 0100/0010 -> result 0x02, remainder 0. DIV 1111/0100 -> 0x03, remainder 3. DIV 0110/0000 -> 0x0F, remainder 6, div_by_zero=1 at cycle 1. Controller 1100 -> illegal_op=1, result 0.
- Backpressure: hold out_ready=0 for 6 cycles after a MUL completes -> result stable, in_ready=0, a new in_valid is ignored. Raising out_ready -> in_ready=1 on the next cycle.
- Drive reset low during ITER count=2 of a MUL -> out_valid=0 and outputs 0 immediately (async). After release, in_ready=1 and a fresh ADD 0011+0001 completes correctly.
